// File: rtl/data_mem_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_mmio                                                |
// | Description : Data-side memory for the core MEM stage. Word-organised RAM   |
// |               with byte-lane writes and combinational reads, plus an MMIO   |
// |               window (base 0x1000_0000) with a GPIO output register and an  |
// |               optional prescaled 32-bit timer with a compare/match flag.    |
// | Ports       : clk, rst (sync, active-high)                                  |
// |               ce_i, we_i, addr_i[31:0], sel_i[3:0], data_i[31:0] - request  |
// |               data_o[31:0]   - combinational read data                      |
// |               gpio_o[GPIO_W] - GPIO output register                         |
// |               timer_irq_o    - level copy of the timer match flag           |
// | Config      : define DATA_MEM_TIMER_EN to build the timer (COUNT, COMPARE,  |
// |               STATUS); otherwise those addresses read 0, irq is tied low.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_mem_mmio #(
   parameter int DEPTH_LOG2 = 12,
   parameter int PRESCALE   = 1,
   parameter int GPIO_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_i,
   input  logic              we_i,
   input  logic [31:0]       addr_i,
   input  logic [3:0]        sel_i,
   input  logic [31:0]       data_i,
   output logic [31:0]       data_o,
   output logic [GPIO_W-1:0] gpio_o,
   output logic              timer_irq_o
);

   localparam int         c_depth    = 2 ** DEPTH_LOG2;
   localparam logic [1:0] c_reg_gpio = 2'd0;

   logic [31:0]           r_mem [0:c_depth-1];
   logic [GPIO_W-1:0]     r_gpio;

   logic                  w_ram_hit;
   logic                  w_mmio_hit;
   logic                  w_rd;
   logic                  w_wr;
   logic                  w_ram_wr;
   logic                  w_gpio_wr;
   logic [DEPTH_LOG2-1:0] w_word;
   logic [31:0]           w_mask;
   logic [31:0]           w_ram_word;
   logic [31:0]           w_gpio_ext;
   logic                  w_unused;

   // Decode. High RAM address bits are ignored, so the RAM aliases through
   // the whole 0x0xxx_xxxx region.
   assign w_ram_hit  = (addr_i[31:28] == 4'h0);
   assign w_mmio_hit = (addr_i[31:4] == 28'h1000000);
   assign w_word     = addr_i[DEPTH_LOG2+1:2];
   assign w_rd       = ce_i & ~we_i;
   assign w_wr       = ce_i & we_i;
   assign w_mask     = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

   // Reset wins over any access presented in the same cycle.
   assign w_ram_wr   = w_wr & w_ram_hit & ~rst;
   assign w_gpio_wr  = w_wr & w_mmio_hit & (addr_i[3:2] == c_reg_gpio);

   assign w_ram_word = r_mem[w_word];

   // Byte-enable RAM; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (w_ram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (sel_i[i]) begin
               r_mem[w_word][8*i +: 8] <= data_i[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gpio <= '0;
      end else if (w_gpio_wr) begin
         r_gpio <= (r_gpio & ~w_mask[GPIO_W-1:0]) | (data_i[GPIO_W-1:0] & w_mask[GPIO_W-1:0]);
      end
   end

   assign gpio_o = r_gpio;

   always_comb begin
      w_gpio_ext             = '0;
      w_gpio_ext[GPIO_W-1:0] = r_gpio;
   end

`ifdef DATA_MEM_TIMER_EN
   localparam logic [1:0]  c_reg_count   = 2'd1;
   localparam logic [1:0]  c_reg_compare = 2'd2;
   localparam logic [1:0]  c_reg_status  = 2'd3;
   localparam logic [31:0] c_presc_last  = 32'(PRESCALE - 1);

   logic [31:0] r_presc;
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_flag;
   logic [31:0] w_count_inc;
   logic        w_tick;
   logic        w_count_wr;
   logic        w_compare_wr;
   logic        w_status_clr;

   assign w_tick       = (r_presc == c_presc_last);
   assign w_count_inc  = r_count + 32'd1;
   assign w_count_wr   = w_wr & w_mmio_hit & (addr_i[3:2] == c_reg_count);
   assign w_compare_wr = w_wr & w_mmio_hit & (addr_i[3:2] == c_reg_compare);
   // W1C obeys lane masking: only lane 0 carries the flag bit.
   assign w_status_clr = w_wr & w_mmio_hit & (addr_i[3:2] == c_reg_status) & sel_i[0] & data_i[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc   <= '0;
         r_count   <= '0;
         r_compare <= 32'hFFFF_FFFF;
         r_flag    <= 1'b0;
      end else begin
         r_presc <= w_tick ? 32'd0 : r_presc + 32'd1;

         // A software COUNT write overrides the tick increment.
         if (w_count_wr) begin
            r_count <= (r_count & ~w_mask) | (data_i & w_mask);
         end else if (w_tick) begin
            r_count <= w_count_inc;
         end

         // Match compares against the COMPARE value held before this edge.
         if (w_compare_wr) begin
            r_compare <= (r_compare & ~w_mask) | (data_i & w_mask);
         end

         // Setting the flag takes precedence over a simultaneous W1C.
         if (w_tick && !w_count_wr && (w_count_inc == r_compare)) begin
            r_flag <= 1'b1;
         end else if (w_status_clr) begin
            r_flag <= 1'b0;
         end
      end
   end

   assign timer_irq_o = r_flag;
`else
   assign timer_irq_o = 1'b0;
`endif

   // Read mux: full word regardless of sel_i; zero when not a read.
   always_comb begin
      data_o = '0;
      if (w_rd) begin
         if (w_ram_hit) begin
            data_o = w_ram_word;
         end else if (w_mmio_hit) begin
            case (addr_i[3:2])
               c_reg_gpio:    data_o = w_gpio_ext;
`ifdef DATA_MEM_TIMER_EN
               c_reg_count:   data_o = r_count;
               c_reg_compare: data_o = r_compare;
               c_reg_status:  data_o = {31'd0, r_flag};
`endif
               default:       data_o = '0;
            endcase
         end
      end
   end

   // Byte-offset bits and (without the timer) upper data bits have no function.
   assign w_unused = ^{addr_i[1:0], data_i};

endmodule
`default_nettype wire

// File: tb/tb_data_mem_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_data_mem_mmio                                             |
// | Description : Self-checking bench for data_mem_mmio. Table of directed     |
// |               RAM/GPIO vectors plus hand sequences for timer, W1C and      |
// |               reset corner cases (timer checks follow DATA_MEM_TIMER_EN).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_data_mem_mmio;

   localparam logic [31:0] c_gpio    = 32'h1000_0000;
   localparam logic [31:0] c_count   = 32'h1000_0004;
   localparam logic [31:0] c_compare = 32'h1000_0008;
   localparam logic [31:0] c_status  = 32'h1000_000C;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [3:0]  sel_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic [15:0] gpio_o;
   logic        timer_irq_o;

   logic [31:0] cnt3_data;
   logic [15:0] gpio3;
   logic        irq3;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        ce;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [15:0] exp_gpio;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   data_mem_mmio #(.DEPTH_LOG2(12), .PRESCALE(1), .GPIO_W(16)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .ce_i        (ce_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .sel_i       (sel_i),
      .data_i      (data_i),
      .data_o      (data_o),
      .gpio_o      (gpio_o),
      .timer_irq_o (timer_irq_o)
   );

   // Second instance, permanently reading COUNT, to observe a prescaler > 1.
   data_mem_mmio #(.DEPTH_LOG2(4), .PRESCALE(3), .GPIO_W(16)) u_dut3 (
      .clk         (clk),
      .rst         (rst),
      .ce_i        (1'b1),
      .we_i        (1'b0),
      .addr_i      (c_count),
      .sel_i       (4'h0),
      .data_i      (32'h0),
      .data_o      (cnt3_data),
      .gpio_o      (gpio3),
      .timer_irq_o (irq3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; checks happen 3 units later.
   task automatic access(input logic ce, input logic we, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
      ce_i = ce; we_i = we; addr_i = a; sel_i = s; data_i = d;
      #3;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      access(1'b1, 1'b1, a, s, d);
      step();
   endtask

   task automatic rd(input string n, input logic [31:0] a, input logic [31:0] e);
      access(1'b1, 1'b0, a, 4'hF, 32'h0);
      check(n, data_o, e);
      step();
   endtask

   task automatic idle_irq(input string n, input logic e);
      access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      check(n, 32'(timer_irq_o), 32'(e));
      step();
   endtask

   task automatic add(input logic ce, input logic we, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic [31:0] erd, input logic [15:0] eg);
      vec_t v;
      v.ce = ce; v.we = we; v.addr = a; v.sel = s; v.wdata = d; v.exp_rd = erd; v.exp_gpio = eg;
      vecs.push_back(v);
   endtask

   initial begin
      // exp_gpio is the register value seen during the cycle, before its edge.
      add(1, 1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0,         16'h0000);
      add(1, 0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, 16'h0000);
      add(1, 1, 32'h0000_0010, 4'h1, 32'h0000_00AA, 32'h0,         16'h0000);
      add(1, 0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEAA, 16'h0000);
      add(1, 1, 32'h0000_0010, 4'h8, 32'h5500_0000, 32'h0,         16'h0000);
      add(1, 0, 32'h0000_0010, 4'hF, 32'h0,         32'h55AD_BEAA, 16'h0000);
      add(1, 0, 32'h0000_0010, 4'h0, 32'h0,         32'h55AD_BEAA, 16'h0000);
      add(1, 1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 32'h0,         16'h0000);
      add(1, 0, 32'h0000_0010, 4'hF, 32'h0,         32'h55AD_BEAA, 16'h0000);
      add(1, 0, 32'h0FFF_C010, 4'hF, 32'h0,         32'h55AD_BEAA, 16'h0000);
      add(1, 1, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 32'h0,         16'h0000);
      add(1, 1, c_gpio,        4'hF, 32'h0000_1234, 32'h0,         16'h0000);
      add(1, 0, c_gpio,        4'hF, 32'h0,         32'h0000_1234, 16'h1234);
      add(1, 1, 32'h2000_0000, 4'hF, 32'hCAFE_F00D, 32'h0,         16'h1234);
      add(1, 0, 32'h2000_0000, 4'hF, 32'h0,         32'h0,         16'h1234);
      add(1, 0, 32'h0000_0000, 4'hF, 32'h0,         32'hA5A5_A5A5, 16'h1234);
      add(1, 1, c_gpio,        4'h6, 32'hABCD_FFFF, 32'h0,         16'h1234);
      add(1, 0, c_gpio,        4'hF, 32'h0,         32'h0000_FF34, 16'hFF34);
      add(1, 1, 32'h1000_0010, 4'hF, 32'h0,         32'h0,         16'hFF34);
      add(0, 0, 32'h0000_0010, 4'hF, 32'h0,         32'h0,         16'hFF34);
      add(0, 1, 32'h0000_0010, 4'hF, 32'h0,         32'h0,         16'hFF34);
      add(1, 0, 32'h0000_0010, 4'hF, 32'h0,         32'h55AD_BEAA, 16'hFF34);
      add(1, 1, 32'h0000_0010, 4'hF, 32'h1111_1111, 32'h0,         16'hFF34);
      add(1, 0, 32'h0000_0010, 4'hF, 32'h0,         32'h1111_1111, 16'hFF34);
      add(1, 0, 32'h1000_0010, 4'hF, 32'h0,         32'h0,         16'hFF34);

      // Reset
      rst = 1'b1;
      ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check("reset.gpio", 32'(gpio_o), 32'h0);
      check("reset.irq", 32'(timer_irq_o), 32'h0);
`ifdef DATA_MEM_TIMER_EN
      check("presc3.cnt0", cnt3_data, 32'd0);
      rd("reset.count", c_count, 32'h0);
      check("presc3.cnt1", cnt3_data, 32'd0);
      rd("reset.compare", c_compare, 32'hFFFF_FFFF);
      check("presc3.cnt2", cnt3_data, 32'd0);
      rd("reset.status", c_status, 32'h0);
      check("presc3.cnt3", cnt3_data, 32'd1);
      repeat (3) step();
      check("presc3.cnt6", cnt3_data, 32'd2);
`else
      check("notimer.cnt3", cnt3_data, 32'h0);
      check("notimer.irq3", 32'(irq3), 32'h0);
      check("notimer.gpio3", 32'(gpio3), 32'h0);
`endif

      // Table-driven RAM / GPIO / decode vectors
      for (int i = 0; i < vecs.size(); i++) begin
         access(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata);
         check($sformatf("vec%0d.data_o", i), data_o, vecs[i].exp_rd);
         check($sformatf("vec%0d.gpio_o", i), 32'(gpio_o), 32'(vecs[i].exp_gpio));
         step();
      end

`ifdef DATA_MEM_TIMER_EN
      // Match with PRESCALE=1: COMPARE=5, COUNT=3 -> flag two edges later
      wr(c_count, 32'h100, 4'hF);
      wr(c_compare, 32'd5, 4'hF);
      wr(c_count, 32'd3, 4'hF);
      idle_irq("match.pre1", 1'b0);
      idle_irq("match.pre2", 1'b0);
      idle_irq("match.rise", 1'b1);
      rd("match.status", c_status, 32'h1);
      wr(c_status, 32'h1, 4'h2);          // wrong lane: no clear
      idle_irq("w1c.masked", 1'b1);
      wr(c_status, 32'h1, 4'h1);
      idle_irq("w1c.clear", 1'b0);
      rd("w1c.status", c_status, 32'h0);
      // W1C in the match cycle: set wins
      wr(c_count, 32'd4, 4'hF);
      wr(c_status, 32'h1, 4'h1);
      idle_irq("w1c.setwins", 1'b1);
      wr(c_status, 32'h1, 4'hF);
      // COMPARE write applies from the next tick only
      wr(c_count, 32'd9, 4'hF);
      wr(c_compare, 32'd10, 4'hF);
      idle_irq("cmp.late", 1'b0);
      wr(c_count, 32'd9, 4'hF);
      idle_irq("cmp.pre", 1'b0);
      idle_irq("cmp.hit", 1'b1);
      // Wrap and write-wins-over-tick
      wr(c_count, 32'hFFFF_FFFF, 4'hF);
      rd("wrap.pre", c_count, 32'hFFFF_FFFF);
      rd("wrap.post", c_count, 32'h0);
      wr(c_count, 32'd7, 4'hF);
      rd("count.wrwins", c_count, 32'd7);
      wr(c_count, 32'hAABB_CCDD, 4'h4);
      rd("count.lane", c_count, 32'h00BB_0008);
      idle_irq("reset.irqpre", 1'b1);
`else
      wr(c_count, 32'hFFFF_FFFF, 4'hF);
      wr(c_compare, 32'h0, 4'hF);
      wr(c_status, 32'h1, 4'hF);
      rd("notimer.count", c_count, 32'h0);
      rd("notimer.compare", c_compare, 32'h0);
      rd("notimer.status", c_status, 32'h0);
      idle_irq("notimer.irq", 1'b0);
`endif

      // Reset mid-run with writes in the reset cycles: both dropped
      access(1'b1, 1'b1, c_gpio, 4'hF, 32'h0000_5A5A);
      rst = 1'b1;
      step();
      access(1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'h0);
      step();
      rst = 1'b0;
      check("rst2.gpio", 32'(gpio_o), 32'h0);
      check("rst2.irq", 32'(timer_irq_o), 32'h0);
`ifdef DATA_MEM_TIMER_EN
      rd("rst2.count", c_count, 32'h0);
`else
      rd("rst2.count", c_count, 32'h0);
`endif
      rd("rst2.ram", 32'h0000_0010, 32'h1111_1111);
      rd("rst2.gpiord", c_gpio, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
